// File: rtl/reuleaux_pkg.sv
// reuleaux_pkg: shared types, constants and fixed-point helper for the Reuleaux triangle drawer
package reuleaux_pkg;
  typedef logic signed [10:0] coord_t;
  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_OCT0, S_OCT1, S_OCT2, S_OCT3, S_OCT4, S_OCT5, S_OCT6, S_OCT7, S_DONE
  } state_t;
  localparam coord_t SCREEN_W = 11'sd160;
  localparam coord_t SCREEN_H = 11'sd120;
  localparam int unsigned SQRT3_6_Q16 = 18919;
  localparam int unsigned SQRT3_3_Q16 = 37837;
  function automatic coord_t scale_q16(input logic [7:0] d, input int unsigned k);
    logic [31:0] p;
    p = {24'd0, d} * k;
    return p[26:16];
  endfunction
endpackage

// File: rtl/circle_octant_gen.sv
// circle_octant_gen: Bresenham midpoint circle engine emitting one octant-mirrored point per octant index
module circle_octant_gen
  import reuleaux_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  coord_t     cen_x,
  input  coord_t     cen_y,
  input  coord_t     radius,
  input  logic       init,
  input  logic       step,
  input  logic [2:0] oct,
  output coord_t     px,
  output coord_t     py,
  output logic       last
);
  coord_t ox, oy, crit, ox_n, oy_n, crit_n, a, b;
  logic neg_x;
  always_comb begin
    oy_n = oy + 11'sd1;
    ox_n = crit <= 11'sd0 ? ox : ox - 11'sd1;
    crit_n = crit + ((crit <= 11'sd0 ? oy_n : oy_n - ox_n) <<< 1) + 11'sd1;
    last = oy_n > ox_n;
    a = oct[0] ? oy : ox;
    b = oct[0] ? ox : oy;
    neg_x = oct[2] ^ oct[1];
    px = cen_x + (neg_x ? -a : a);
    py = cen_y + (oct[2] ? -b : b);
  end
  always_ff @(posedge clk)
    if (rst) begin
      ox <= '0;
      oy <= '0;
      crit <= '0;
    end else if (init) begin
      ox <= radius;
      oy <= '0;
      crit <= 11'sd1 - radius;
    end else if (step) begin
      ox <= ox_n;
      oy <= oy_n;
      crit <= crit_n;
    end
endmodule

// File: rtl/reuleaux_drawer.sv
// reuleaux_drawer: rasterises a clipped Reuleaux triangle outline as three filtered Bresenham arcs
module reuleaux_drawer
  import reuleaux_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] diameter,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);
  state_t state, state_n;
  logic [1:0] k;
  logic [2:0] col_q;
  logic [7:0] cx_q, d_q;
  logic [6:0] cy_q;
  coord_t ccx, ccy, h6, h3, v1x, v2x, v12y, v3y, cen_x, cen_y, radius, px, py;
  logic last, on_arc, in_bounds, oct_st;
  assign ccx = {3'b0, cx_q};
  assign ccy = {4'b0, cy_q};
  assign radius = {3'b0, d_q};
  assign h6 = scale_q16(d_q, SQRT3_6_Q16);
  assign h3 = scale_q16(d_q, SQRT3_3_Q16);
  assign v1x = ccx + {4'b0, d_q[7:1]};
  assign v2x = ccx - {4'b0, d_q[7:1]};
  assign v12y = ccy + h6;
  assign v3y = ccy - h3;
  assign cen_x = k == 2'd0 ? v1x : k == 2'd1 ? v2x : ccx;
  assign cen_y = k == 2'd2 ? v3y : v12y;
  circle_octant_gen u_gen (
    .clk   (clk),
    .rst   (rst_n),
    .cen_x (cen_x),
    .cen_y (cen_y),
    .radius(radius),
    .init  (state == S_INIT),
    .step  (state == S_OCT7),
    .oct   (3'(state - S_OCT0)),
    .px    (px),
    .py    (py),
    .last  (last)
  );
  always_comb begin
    state_n = state == S_IDLE ? (start ? S_INIT : S_IDLE) :
              state == S_INIT ? S_OCT0 :
              state == S_OCT7 ? (last ? (k == 2'd2 ? S_DONE : S_INIT) : S_OCT0) :
              state == S_DONE ? (start ? S_DONE : S_IDLE) :
              state_t'(state + 4'd1);
    on_arc = k == 2'd0 ? (px <= ccx && py <= v12y) :
             k == 2'd1 ? (px >= ccx && py <= v12y) : (py >= v12y);
    in_bounds = px >= 11'sd0 && px < SCREEN_W && py >= 11'sd0 && py < SCREEN_H;
    oct_st = state >= S_OCT0 && state <= S_OCT7;
    done = state == S_DONE;
    vga_plot = oct_st && on_arc && in_bounds;
    vga_x = oct_st ? px[7:0] : 8'd0;
    vga_y = oct_st ? py[6:0] : 7'd0;
    vga_colour = col_q;
  end
  always_ff @(posedge clk)
    if (rst_n) begin
      state <= S_IDLE;
      k <= '0;
      col_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      d_q <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start) begin
        k <= '0;
        col_q <= colour;
        cx_q <= centre_x;
        cy_q <= centre_y;
        d_q <= diameter;
      end
      if (state == S_OCT7 && last) k <= k + 2'd1;
    end
endmodule

// File: tb/tb_reuleaux_drawer.sv
// tb_reuleaux_drawer: self-checking bench comparing the drawer against a cycle-level arc model
module tb_reuleaux_drawer;
  logic clk = 0, rst_n = 1, start = 0;
  logic [2:0] colour = 0;
  logic [7:0] centre_x = 0, diameter = 0;
  logic [6:0] centre_y = 0;
  logic done, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  reuleaux_drawer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .colour(colour),
    .centre_x(centre_x), .centre_y(centre_y), .diameter(diameter),
    .done(done), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );
  typedef struct {bit p; int x; int y;} cand_t;
  typedef struct {int cx; int cy; int d; int col; int px; int py; bit inner;} vec_t;
  cand_t exp_q[$];
  bit seen[160][120];
  vec_t vecs[4];
  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  function automatic void build(input int cx, input int cy, input int d);
    int h6, h3, ox, oy, e, x, y;
    int vx[3], vy[3], dx[8], dy[8];
    bit arc;
    h6 = (d * 18919) >> 16;
    h3 = (d * 37837) >> 16;
    vx = '{cx + d / 2, cx - d / 2, cx};
    vy = '{cy + h6, cy + h6, cy - h3};
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      ox = d;
      oy = 0;
      e = 1 - d;
      exp_q.push_back('{1'b0, 0, 0});
      while (oy <= ox) begin
        dx = '{ox, oy, -ox, -oy, -ox, -oy, ox, oy};
        dy = '{oy, ox, oy, ox, -oy, -ox, -oy, -ox};
        for (int i = 0; i < 8; i++) begin
          x = vx[k] + dx[i];
          y = vy[k] + dy[i];
          arc = k == 0 ? (x <= vx[2] && y <= vy[0]) : k == 1 ? (x >= vx[2] && y <= vy[1]) : (y >= vy[0]);
          exp_q.push_back('{arc && x >= 0 && x < 160 && y >= 0 && y < 120, x, y});
        end
        oy++;
        if (e <= 0) e += 2 * oy + 1;
        else begin
          ox--;
          e += 2 * (oy - ox) + 1;
        end
      end
    end
  endfunction
  task automatic draw(input int cx, input int cy, input int d, input int col, input string tag);
    int errs = 0;
    build(cx, cy, d);
    foreach (seen[i, j]) seen[i][j] = 0;
    centre_x = 8'(cx);
    centre_y = 7'(cy);
    diameter = 8'(d);
    colour = 3'(col);
    start = 1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
      if (vga_plot !== exp_q[i].p || done !== 1'b0) errs++;
      if (exp_q[i].p && (int'(vga_x) != exp_q[i].x || int'(vga_y) != exp_q[i].y || vga_colour !== 3'(col))) errs++;
      if (vga_plot && (vga_x >= 160 || vga_y >= 120)) errs++;
      else if (vga_plot) seen[vga_x][vga_y] = 1;
    end
    @(posedge clk);
    #1;
    check({tag, " sequence errors"}, errs, 0);
    check({tag, " done"}, done, 1);
  endtask
  task automatic release_start(input string tag);
    start = 0;
    @(posedge clk);
    #1;
    check({tag, " done drop"}, done, 0);
    check({tag, " idle xy"}, {vga_x, vga_y, vga_plot}, 0);
  endtask
  initial begin
    int inner;
    vecs[0] = '{80, 60, 80, 2, 40, 83, 1'b1};
    vecs[1] = '{80, 60, 80, 2, 120, 83, 1'b0};
    vecs[2] = '{80, 60, 80, 2, 80, 94, 1'b0};
    vecs[3] = '{30, 20, 80, 2, 70, 43, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    check("reset done", done, 0);
    check("reset plot", vga_plot, 0);
    check("reset xy", {vga_x, vga_y}, 0);
    check("reset colour", vga_colour, 0);
    rst_n = 0;
    for (int v = 0; v < 4; v++) begin
      draw(vecs[v].cx, vecs[v].cy, vecs[v].d, vecs[v].col, $sformatf("vec%0d", v));
      check($sformatf("vec%0d pixel (%0d,%0d)", v, vecs[v].px, vecs[v].py), seen[vecs[v].px][vecs[v].py], 1);
      if (vecs[v].inner) begin
        inner = 0;
        foreach (seen[i, j]) if (seen[i][j] && (i - 80) * (i - 80) + (j - 60) * (j - 60) < 900) inner++;
        check("arc filter inner pixels", inner, 0);
      end
      repeat (3) begin
        @(posedge clk);
        #1;
        check($sformatf("vec%0d done held", v), done, 1);
      end
      release_start($sformatf("vec%0d", v));
    end
    draw(10, 10, 0, 5, "d0 visible");
    release_start("d0 visible");
    draw(200, 5, 0, 6, "d0 clipped");
    release_start("d0 clipped");
    for (int r = 0; r < 6; r++) begin
      draw($urandom_range(255), $urandom_range(127), $urandom_range(120), $urandom_range(7), $sformatf("rand%0d", r));
      release_start($sformatf("rand%0d", r));
    end
    centre_x = 80;
    centre_y = 60;
    diameter = 80;
    colour = 5;
    start = 1;
    repeat (100) @(posedge clk);
    rst_n = 1;
    start = 0;
    @(posedge clk);
    #1;
    check("midreset plot", vga_plot, 0);
    check("midreset done", done, 0);
    check("midreset xy", {vga_x, vga_y}, 0);
    check("midreset colour", vga_colour, 0);
    rst_n = 0;
    @(posedge clk);
    #1;
    check("midreset stays idle", {vga_plot, done}, 0);
    draw(80, 60, 80, 3, "after reset");
    release_start("after reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
